// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Holds the operation encoding, FSM states and small operand helpers.
package muldiv_sequencer_pkg;

    // Encoding follows the RV32M funct3 field so decode can pass it straight through.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    localparam int          MULDIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic rs1_is_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input muldiv_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer signal bundle.
// Handshake: start is held by execute while the instruction sits there; stall freezes
// the pipeline until done pulses for one cycle, which is the only cycle result is valid.
interface muldiv_sequencer_if;
    import muldiv_sequencer_pkg::*;

    logic        start;
    muldiv_op_t  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, rs1_val, rs2_val, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, flush,
        output stall, done, result
    );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One radix-2 iteration: a shift-add multiply step or a restoring divide step.
// Purely combinational; the sequencer owns all registers.
module muldiv_step
    import muldiv_sequencer_pkg::*;
(
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [63:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc_next,
    output logic [63:0] opa_next,
    output logic [31:0] opb_next
);

    logic        fits;
    logic [31:0] sub;

    // Divide: acc = {partial remainder, dividend/quotient bits}; the shifted remainder
    // is 33 bits wide, so compare against the divisor before subtracting.
    always_comb begin
        fits     = acc[63:31] >= {1'b0, opb};
        sub      = acc[62:31] - opb;
        acc_next = acc;
        opa_next = opa;
        opb_next = opb;
        if (div_mode) begin
            if (fits) begin
                acc_next = {sub, acc[30:0], 1'b1};
            end else begin
                acc_next = {acc[62:0], 1'b0};
            end
        end else begin
            if (opb[0]) begin
                acc_next = acc + opa;
            end
            opa_next = {opa[62:0], 1'b0};
            opb_next = {1'b0, opb[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency iterative RV32M multiply/divide unit for the execute stage.
// Operands are latched as magnitudes; signs are reapplied when the last step completes.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus,
    output muldiv_state_t       fsm_state
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITER - 1);

    muldiv_state_t state, state_next;
    logic [4:0]    count;
    muldiv_op_t    op_q;
    logic [63:0]   acc, opa;
    logic [31:0]   opb;
    logic          neg_q, rem_neg_q;
    logic [31:0]   result_q;

    logic          accept, load_special, last_step;
    logic [31:0]   rs1_mag, rs2_mag;
    logic          rs1_neg, rs2_neg;
    logic          div_zero, div_ovf, special;
    logic [31:0]   special_val;
    logic [63:0]   step_acc, step_opa;
    logic [31:0]   step_opb;
    logic [63:0]   prod;
    logic [31:0]   quot, rem, final_val;

    assign fsm_state  = state;
    assign bus.result = result_q;

    // Operand classification on the incoming instruction.
    always_comb begin
        rs1_neg  = rs1_is_signed(bus.op) && bus.rs1_val[31];
        rs2_neg  = rs2_is_signed(bus.op) && bus.rs2_val[31];
        rs1_mag  = magnitude(bus.rs1_val, rs1_is_signed(bus.op));
        rs2_mag  = magnitude(bus.rs2_val, rs2_is_signed(bus.op));
        div_zero = is_div(bus.op) && (bus.rs2_val == 32'd0);
        div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                   (bus.rs1_val == INT_MIN) && (bus.rs2_val == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        special_val = 32'd0;
        if (div_zero) begin
            special_val = bus.op[1] ? bus.rs1_val : DIV_ZERO_QUOT;
        end else if (div_ovf) begin
            special_val = bus.op[1] ? 32'd0 : INT_MIN;
        end
    end

    muldiv_step u_step (
        .div_mode (is_div(op_q)),
        .acc      (acc),
        .opa      (opa),
        .opb      (opb),
        .acc_next (step_acc),
        .opa_next (step_opa),
        .opb_next (step_opb)
    );

    // Sign fix-up applied to the output of the final iteration.
    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        quot = neg_q ? -step_acc[31:0] : step_acc[31:0];
        rem  = rem_neg_q ? -step_acc[63:32] : step_acc[63:32];
        case (op_q)
            OP_MUL:                       final_val = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod[63:32];
            OP_DIV, OP_DIVU:              final_val = quot;
            default:                      final_val = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.stall    = 1'b0;
        bus.done     = 1'b0;
        accept       = 1'b0;
        load_special = 1'b0;
        last_step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    bus.stall = 1'b1;
                    if (special) begin
                        load_special = 1'b1;
                        state_next   = FINISH;
                    end else begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                bus.stall = 1'b1;
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (count == LAST_ITER) begin
                    last_step  = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                // A flush landing on the finish cycle kills the instruction, so no pulse.
                bus.done   = !bus.flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 5'd0;
            op_q      <= OP_MUL;
            acc       <= 64'd0;
            opa       <= 64'd0;
            opb       <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            if (accept) begin
                op_q      <= bus.op;
                count     <= 5'd0;
                acc       <= is_div(bus.op) ? {32'd0, rs1_mag} : 64'd0;
                opa       <= is_div(bus.op) ? 64'd0 : {32'd0, rs1_mag};
                opb       <= rs2_mag;
                neg_q     <= rs1_neg ^ rs2_neg;
                rem_neg_q <= rs1_neg;
            end else if (load_special) begin
                op_q     <= bus.op;
                count    <= 5'd0;
                result_q <= special_val;
            end else if (state == CALC && !bus.flush) begin
                acc   <= step_acc;
                opa   <= step_opa;
                opb   <= step_opb;
                count <= count + 5'd1;
                if (last_step) begin
                    result_q <= final_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall shape, results, flush and reset.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    muldiv_state_t fsm_state;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   exp_q[$];

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one instruction, scrambles inputs after acceptance, checks latency/stall/result.
    task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit special);
        int          n;
        int          stall_cycles;
        bit          seen;
        logic [31:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.flush   = 1'b0;
        #1 stall_cycles = bus.stall ? 1 : 0;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = OP_REMU;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = (n == 5);
            #1;
            if (bus.done) seen = 1'b1;
            else if (bus.stall) stall_cycles++;
        end
        bus.start = 1'b0;
        want = exp_q.pop_front();
        check_eq({tag, " latency"}, 32'(n), special ? 32'd1 : 32'd33);
        check_eq({tag, " stall cycles"}, 32'(stall_cycles), special ? 32'd1 : 32'd33);
        check_eq({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check_eq({tag, " stall at done"}, {31'd0, bus.stall}, 32'd0);
        check_eq({tag, " result"}, bus.result, want);
        @(negedge clk);
        #1;
        check_eq({tag, " done width"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, " result hold"}, bus.result, want);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.op      = OP_MUL;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        bus.flush   = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset state", 32'(fsm_state), 32'(IDLE));
        check_eq("reset result", bus.result, 32'd0);
        check_eq("reset done", {31'd0, bus.done}, 32'd0);
        check_eq("reset stall", {31'd0, bus.stall}, 32'd0);
        reset = 1'b0;

        run_op("mul 7*-3",        OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu -1*-1",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh -1*-1",      OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("mulhsu -1*2",     OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("div -7/2",        OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("rem -7%2",        OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("divu 100/7",      OP_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
        run_op("remu 100%7",      OP_REMU,   32'd100,        32'd7,         32'd2,         1'b0);
        run_op("divu max/1",      OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0);
        run_op("div by zero",     OP_DIV,    32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1);
        run_op("remu by zero",    OP_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1);
        run_op("div overflow",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem overflow",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // Flush at CALC iteration 10.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_val = 32'd5; bus.rs2_val = 32'd6;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check_eq("flush state", 32'(fsm_state), 32'(IDLE));
        check_eq("flush stall", {31'd0, bus.stall}, 32'd0);
        check_eq("flush done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check_eq("flush no late done", {31'd0, bus.done}, 32'd0);
        run_op("mul after flush", OP_MUL, 32'd5, 32'd6, 32'd30, 1'b0);

        // Reset at CALC iteration 20.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (21) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midreset state", 32'(fsm_state), 32'(IDLE));
        check_eq("midreset stall", {31'd0, bus.stall}, 32'd0);
        check_eq("midreset done", {31'd0, bus.done}, 32'd0);
        check_eq("midreset result", bus.result, 32'd0);

        // Start and flush together in IDLE.
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL;
        #1 check_eq("start+flush stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("start+flush state", 32'(fsm_state), 32'(IDLE));
        bus.start = 1'b0; bus.flush = 1'b0;

        run_op("divu after reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: the execute stage holds an M-extension instruction.
REQ-004 SHALL have port op, input, muldiv_op_t (3 bits): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-005 SHALL have port rs1_val, input, 32 bits: forwarded left operand.
REQ-006 SHALL have port rs2_val, input, 32 bits: forwarded right operand.
REQ-007 SHALL have port flush, input, 1 bit: a branch or jalr redirect kills the instruction in execute.
REQ-008 SHALL have port stall, output, 1 bit: freeze the fetch, decode and execute pipeline registers.
REQ-009 SHALL have port done, output, 1 bit: a single-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32 bits: value for the execute-stage alu_data mux.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and FINISH.
REQ-012 IDLE: start=1 with flush=0 and an ordinary operation SHALL latch op and operands, clear the 5-bit counter and move to CALC.
REQ-013 IDLE: start=1 with flush=0 and a special-case division (REQ-018, REQ-019) SHALL load the special result and move directly to FINISH.
REQ-014 CALC SHALL perform one iteration per cycle; the counter increments 0 to 31, and count==31 SHALL move to FINISH.
REQ-015 FINISH SHALL drive done=1 and a valid result for exactly one cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed: start sampled at cycle T gives done at T+33 (ordinary) or T+1 (special); done never depends on operand values otherwise.
REQ-017 stall SHALL be combinational: (IDLE and start and not flush) or CALC; stall SHALL be 0 in FINISH so the pipeline captures result that cycle.
REQ-018 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rs1_val.
REQ-019 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-020 Multiply SHALL use a radix-2 shift-add over operand magnitudes into a 64-bit accumulator; signed variants SHALL negate the 64-bit product when the signs differ. MUL returns bits [31:0]; the MULH variants return [63:32].
REQ-021 Divide SHALL use radix-2 restoring division on magnitudes. The quotient sign is sign(rs1) XOR sign(rs2); the remainder sign is sign(rs1). Unsigned ops SHALL skip all sign handling.
REQ-022 All internal arithmetic SHALL be performed at full width with no truncation before the final 32-bit select.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge with no done pulse; flush wins over a simultaneous start.
REQ-024 start while in CALC or FINISH SHALL be ignored; latched operands SHALL be immune to input changes after acceptance.
REQ-025 result SHALL hold its last value outside FINISH; it is qualified by done only.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, counter=0, done=0, result=0 and clear all operand and accumulator registers.
REQ-027 Reset mid-CALC SHALL abort with no done pulse; stall SHALL be 0 in the cycle after reset unless start is asserted.

Structure
REQ-028 muldiv_op_t and the constants MULDIV_ITER=32 and DIV_ZERO_QUOT=32'hFFFFFFFF SHALL live in the shared common package.
REQ-029 The per-iteration arithmetic (one shift-add or one restoring subtract step) SHALL be a combinational sub-module named muldiv_step; the FSM, counter and sign fix-up stay in muldiv_sequencer.
REQ-030 The execute stage SHALL select result when done=1, and the hazard logic SHALL OR stall into its freeze signal.

Verification
REQ-031 MUL with 7 and -3 (0xFFFFFFFD) -> stall high for 33 cycles, then done at T+33 with result=0xFFFFFFEB.
REQ-032 MULHU with 0xFFFFFFFF and 0xFFFFFFFF -> result=0xFFFFFFFE; MULH on the same operands -> result=0x00000000.
REQ-033 DIV with -7 and 2 -> result=0xFFFFFFFD (-3); REM on the same operands -> 0xFFFFFFFF (-1); DIVU with 100 and 7 -> 14.
REQ-034 DIV by 0 with rs1=0x1234 -> done at T+1 with 0xFFFFFFFF; REMU by 0 -> 0x1234; DIV 0x80000000 by -1 -> 0x80000000 at T+1.
REQ-035 flush asserted at CALC cycle 10 -> IDLE next cycle, no done, stall=0; a new start two cycles later completes correctly.
REQ-036 reset pulsed at CALC cycle 20 -> all outputs 0 the next cycle; start and flush asserted together in IDLE -> no state change and stall=0.
